// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser: FSM state encoding,
// response byte values and the default start-of-frame marker.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_PAYLOAD,
    GET_CHK,
    DRAIN,
    RESP
  } state_e;

  localparam logic [7:0] ACK_BYTE    = 8'h06;
  localparam logic [7:0] NAK_BYTE    = 8'h15;
  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-level bus of the frame parser: UART rx/tx side, downstream payload
// stream and status. master = parser side, slave = environment side.
interface uart_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, m_ready,
    output tx_send, tx_data, m_data, m_valid, m_last, frame_err, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, m_ready,
    input  tx_send, tx_data, m_data, m_valid, m_last, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_parser_frame_buffer.sv
// frame_buffer: payload store for one frame. Single write port, single
// combinational read port addressed by an internal registered read index
// that is cleared at frame start and stepped once per downstream transfer.
module frame_buffer #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             rd_clr,
  input  logic             rd_adv,
  output logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  // payload write; storage needs no reset, only the index does
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // read index: restart per frame, advance on each accepted byte
  always_ff @(posedge clk) begin
    if (!reset_n)    rd_idx <= '0;
    else if (rd_clr) rd_idx <= '0;
    else if (rd_adv) rd_idx <= rd_idx + 1'b1;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses SOF, LEN, payload, CHK frames from a UART byte
// stream, releases the payload downstream only after the XOR checksum
// matches, and answers each accepted SOF with ACK or NAK on the tx side.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = DEFAULT_SOF,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  uart_frame_parser_if.master bus
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_frame_parser: illegal parameter set");
  end

  state_e           state, nxt;
  logic [7:0]       len_q, idx_q, chk_q;
  logic             ack_q, m_valid_q, frame_err_q;
  logic             nak_set, ack_set, len_ld, wr_en, rd_adv, m_last, timeout;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;

`ifdef FRAME_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        waiting;

  assign waiting = (state == GET_LEN) || (state == GET_PAYLOAD) || (state == GET_CHK);

  // cycles since the last received byte while a frame is partially in
  always_ff @(posedge clk) begin
    if (!reset_n)                     to_cnt <= '0;
    else if (bus.rx_valid || !waiting) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 32'd1;
  end

  assign timeout = waiting && !bus.rx_valid && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign m_last = m_valid_q && (8'(rd_idx) == len_q - 8'd1);

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    nxt     = state;
    nak_set = 1'b0;
    ack_set = 1'b0;
    len_ld  = 1'b0;
    wr_en   = 1'b0;
    rd_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SOF_BYTE) nxt = GET_LEN;
      end
      GET_LEN: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            nak_set = 1'b1;
            nxt     = RESP;
          end else begin
            len_ld = 1'b1;
            nxt    = GET_PAYLOAD;
          end
        end
      end
      GET_PAYLOAD: begin
        if (bus.rx_valid) begin
          wr_en = 1'b1;
          if (idx_q == len_q - 8'd1) nxt = GET_CHK;
        end
      end
      GET_CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == chk_q) begin
            ack_set = 1'b1;
            nxt     = DRAIN;
          end else begin
            nak_set = 1'b1;
            nxt     = RESP;
          end
        end
      end
      DRAIN: begin
        if (m_valid_q && bus.m_ready) begin
          rd_adv = 1'b1;
          if (m_last) nxt = RESP;
        end
      end
      RESP: begin
        if (bus.tx_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // a stalled partial frame is rejected the same way as a bad length
    if (timeout) begin
      nak_set = 1'b1;
      nxt     = RESP;
    end
  end

  // frame datapath: length, write index, running checksum, response choice
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      ack_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= nak_set;
      // valid rises one cycle into DRAIN and drops with the last transfer
      m_valid_q   <= (state == DRAIN) && (nxt == DRAIN);
      if (ack_set)      ack_q <= 1'b1;
      else if (nak_set) ack_q <= 1'b0;
      if (len_ld) begin
        len_q <= bus.rx_data;
        chk_q <= bus.rx_data;
        idx_q <= '0;
      end else if (wr_en) begin
        chk_q <= chk_q ^ bus.rx_data;
        idx_q <= idx_q + 8'd1;
      end
    end
  end

  frame_buffer #(.DEPTH(MAX_LEN), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_idx  (idx_q[IDX_W-1:0]),
    .wr_data (bus.rx_data),
    .rd_clr  (len_ld),
    .rd_adv  (rd_adv),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_valid_q ? rd_data : 8'h00;
  assign bus.m_last    = m_last;
  assign bus.tx_send   = (state == RESP) && bus.tx_ready;
  assign bus.tx_data   = (state == RESP) ? (ack_q ? ACK_BYTE : NAK_BYTE) : 8'h00;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: reset values, good/bad frames,
// length boundaries, backpressure, tx stall, resets mid-frame and the
// optional timeout (FRAME_TIMEOUT_EN).
module tb_uart_frame_parser;
  import uart_frame_parser_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   tx_cnt  = 0;
  int   ferr_cnt = 0;
  int   mv_cnt  = 0;
  logic [7:0] last_tx = 8'h00;
  logic [8:0] got [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .SOF_BYTE       (8'hA5),
    .MAX_LEN        (64),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // outputs sampled at negedge; inputs only change 1ns after posedge
  always @(negedge clk) begin
    if (reset_n && prev_stall) begin
      check("hold_valid", 32'(bus.m_valid), 32'd1);
      check("hold_data",  32'(bus.m_data),  32'(prev_data));
      check("hold_last",  32'(bus.m_last),  32'(prev_last));
    end
    prev_stall = reset_n && bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    prev_last  = bus.m_last;
    if (bus.m_valid) mv_cnt++;
    if (bus.m_valid && bus.m_ready) got.push_back({bus.m_last, bus.m_data});
    if (bus.tx_send) begin
      tx_cnt++;
      last_tx = bus.tx_data;
    end
    if (bus.frame_err) ferr_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int start;
    int n;
    start = tx_cnt;
    n = 0;
    while (tx_cnt == start && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(tx_cnt - start), 32'd1);
  endtask

  task automatic check_byte(input string tag, input int i, input logic [8:0] e);
    logic [8:0] o;
    o = (i < got.size()) ? got[i] : 9'h1FF;
    check(tag, 32'(o), 32'(e));
  endtask

  task automatic clear_obs();
    got.delete();
    ferr_cnt = 0;
    mv_cnt   = 0;
  endtask

  initial begin
    int base;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.m_ready  = 1'b1;
    reset_n      = 1'b0;
    step(3);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_tx_send",   32'(bus.tx_send),   32'd0);
    check("rst_m_valid",   32'(bus.m_valid),   32'd0);
    check("rst_m_last",    32'(bus.m_last),    32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_tx_data",   32'(bus.tx_data),   32'h00);
    check("rst_m_data",    32'(bus.m_data),    32'h00);
    reset_n = 1'b1;
    step(1);

    // noise in IDLE is dropped, then a good 3-byte frame
    clear_obs();
    send(8'h00); send(8'h5A);
    check("noise_busy", 32'(bus.busy), 32'd0);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    wait_tx("t1_tx", 50);
    check("t1_tx_data", 32'(last_tx), 32'h06);
    check("t1_count", 32'(got.size()), 32'd3);
    check_byte("t1_b0", 0, {1'b0, 8'h11});
    check_byte("t1_b1", 1, {1'b0, 8'h22});
    check_byte("t1_b2", 2, {1'b1, 8'h33});
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    check("t1_idle", 32'(bus.busy), 32'd0);

    // bad checksum: nothing released, NAK
    clear_obs();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    wait_tx("t2_tx", 50);
    check("t2_tx_data", 32'(last_tx), 32'h15);
    check("t2_ferr", 32'(ferr_cnt), 32'd1);
    check("t2_no_valid", 32'(mv_cnt), 32'd0);

    // LEN=0 and LEN=MAX_LEN+1 rejected
    clear_obs();
    send(8'hA5); send(8'h00);
    wait_tx("t3_len0_tx", 20);
    check("t3_len0_nak", 32'(last_tx), 32'h15);
    check("t3_len0_idle", 32'(bus.busy), 32'd0);
    send(8'hA5); send(8'h41);
    wait_tx("t3_len41_tx", 20);
    check("t3_len41_nak", 32'(last_tx), 32'h15);
    check("t3_len41_idle", 32'(bus.busy), 32'd0);
    check("t3_ferr", 32'(ferr_cnt), 32'd2);
    check("t3_no_valid", 32'(mv_cnt), 32'd0);

    // LEN=1 boundary: 01 ^ 7E = 7F
    clear_obs();
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    wait_tx("t4_tx", 20);
    check("t4_ack", 32'(last_tx), 32'h06);
    check("t4_count", 32'(got.size()), 32'd1);
    check_byte("t4_b0", 0, {1'b1, 8'h7E});

    // LEN=MAX_LEN boundary: payload 00..3F xors to 0, so CHK = 40
    clear_obs();
    send(8'hA5); send(8'h40);
    for (int i = 0; i < 64; i++) send(8'(i));
    send(8'h40);
    wait_tx("t5_tx", 200);
    check("t5_ack", 32'(last_tx), 32'h06);
    check("t5_count", 32'(got.size()), 32'd64);
    for (int i = 0; i < 64; i++) check_byte("t5_byte", i, {(i == 63), 8'(i)});

    // backpressure 1-0-0-1 and tx stall; rx during DRAIN ignored
    // CHK = 03 ^ AA ^ BB ^ CC = DE
    clear_obs();
    base = tx_cnt;
    bus.m_ready  = 1'b0;
    bus.tx_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDE);
    step(2);
    check("t6_stall_valid", 32'(bus.m_valid), 32'd1);
    check("t6_stall_data", 32'(bus.m_data), 32'hAA);
    send(8'hA5);
    bus.m_ready = 1'b1; step(1);
    bus.m_ready = 1'b0; step(2);
    bus.m_ready = 1'b1; step(1);
    bus.m_ready = 1'b0; step(1);
    bus.m_ready = 1'b1; step(1);
    step(10);
    check("t6_no_tx_while_stalled", 32'(tx_cnt - base), 32'd0);
    check("t6_busy_in_resp", 32'(bus.busy), 32'd1);
    bus.tx_ready = 1'b1;
    wait_tx("t6_tx", 5);
    check("t6_ack", 32'(last_tx), 32'h06);
    check("t6_count", 32'(got.size()), 32'd3);
    check_byte("t6_b0", 0, {1'b0, 8'hAA});
    check_byte("t6_b1", 1, {1'b0, 8'hBB});
    check_byte("t6_b2", 2, {1'b1, 8'hCC});
    check("t6_idle", 32'(bus.busy), 32'd0);

    // reset mid-payload: no response, clean recovery
    clear_obs();
    base = tx_cnt;
    send(8'hA5); send(8'h03); send(8'h11);
    reset_n = 1'b0; step(2); reset_n = 1'b1;
    step(5);
    check("t7_no_tx", 32'(tx_cnt - base), 32'd0);
    check("t7_idle", 32'(bus.busy), 32'd0);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h54);
    wait_tx("t7_recover_tx", 20);
    check("t7_recover_ack", 32'(last_tx), 32'h06);
    check_byte("t7_recover_b0", 0, {1'b1, 8'h55});

    // reset mid-drain: valid drops, nothing else emerges
    clear_obs();
    base = tx_cnt;
    bus.m_ready = 1'b0;
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h01);
    step(2);
    check("t8_valid_before", 32'(bus.m_valid), 32'd1);
    reset_n = 1'b0; step(1);
    check("t8_valid_after", 32'(bus.m_valid), 32'd0);
    reset_n = 1'b1;
    bus.m_ready = 1'b1;
    step(5);
    check("t8_no_transfer", 32'(got.size()), 32'd0);
    check("t8_no_tx", 32'(tx_cnt - base), 32'd0);

`ifdef FRAME_TIMEOUT_EN
    // partial frame times out into NAK
    clear_obs();
    send(8'hA5); send(8'h02); send(8'h11);
    wait_tx("t9_timeout_tx", 101);
    check("t9_timeout_nak", 32'(last_tx), 32'h15);
    check("t9_timeout_ferr", 32'(ferr_cnt), 32'd1);
    check("t9_timeout_idle", 32'(bus.busy), 32'd0);
`else
    // without the timeout a partial frame waits indefinitely
    base = tx_cnt;
    send(8'hA5); send(8'h02); send(8'h11);
    step(200);
    check("t9_no_timeout_tx", 32'(tx_cnt - base), 32'd0);
    check("t9_still_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0; step(1); reset_n = 1'b1; step(1);
    check("t9_idle_after_rst", 32'(bus.busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 The block SHALL have parameter SOF_BYTE, default 8'hA5, the start-of-frame marker.
REQ-002 The block SHALL have parameter MAX_LEN, default 64, the largest legal payload length (1..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 500000, the inter-byte timeout in clk cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: one-cycle pulse qualifying rx_data.
REQ-008 The block SHALL have port tx_ready, input, 1 bit: UART transmitter can accept a byte.
REQ-009 The block SHALL have port tx_send, output, 1 bit: one-cycle pulse sending tx_data.
REQ-010 The block SHALL have port tx_data, output, 8 bits: response byte.
REQ-011 The block SHALL have port m_data, output, 8 bits: payload byte to the downstream stage.
REQ-012 The block SHALL have port m_valid, output, 1 bit: m_data valid.
REQ-013 The block SHALL have port m_last, output, 1 bit: marks the final payload byte.
REQ-014 The block SHALL have port m_ready, input, 1 bit: downstream accepts m_data.
REQ-015 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a rejected frame.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 Frame format SHALL be SOF_BYTE, LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-018 The state machine SHALL have exactly the states IDLE, GET_LEN, GET_PAYLOAD, GET_CHK, DRAIN, RESP.
REQ-019 In IDLE, a byte equal to SOF_BYTE SHALL move the FSM to GET_LEN; any other byte SHALL be silently discarded.
REQ-020 In GET_LEN, LEN=0 or LEN>MAX_LEN SHALL select NAK and move to RESP; otherwise the FSM SHALL store LEN, seed the checksum with LEN, and move to GET_PAYLOAD.
REQ-021 In GET_PAYLOAD, each byte SHALL be written to a MAX_LEN-deep buffer at index 0..LEN-1 and XORed into the checksum; after byte LEN the FSM SHALL move to GET_CHK.
REQ-022 In GET_CHK, a match SHALL move to DRAIN with ACK selected; a mismatch SHALL select NAK and move to RESP.
REQ-023 Payload SHALL be released only after a checksum match; no byte of a rejected frame SHALL appear on m_data.
REQ-024 In DRAIN, m_valid SHALL stay high and buffer bytes SHALL present in order, advancing only on m_valid&&m_ready, with m_last high on index LEN-1; after the last transfer the FSM SHALL move to RESP.
REQ-025 m_data, m_last SHALL hold stable while m_valid&&!m_ready.
REQ-026 In RESP, tx_send SHALL pulse for one cycle in the first cycle tx_ready is high, with tx_data=8'h06 (ACK) or 8'h15 (NAK), then the FSM SHALL return to IDLE.
REQ-027 frame_err SHALL pulse one cycle on each transition into RESP with NAK selected.
REQ-028 rx_valid bytes arriving in DRAIN or RESP SHALL be discarded and SHALL NOT affect state.
REQ-029 Per-byte latency: state/buffer update SHALL occur on the edge where rx_valid is sampled; m_valid SHALL rise the cycle after entering DRAIN.

Reset
REQ-030 While reset_n is low at a clk edge, the FSM SHALL enter IDLE and tx_send, m_valid, m_last, frame_err, busy SHALL be 0, with tx_data, m_data at 8'h00 and counters and checksum cleared.
REQ-031 Reset mid-frame or mid-drain SHALL abandon the frame with no response and no further m_valid.

Configuration
REQ-032 With FRAME_TIMEOUT_EN defined, a counter SHALL clear on every rx_valid and, in GET_LEN/GET_PAYLOAD/GET_CHK, reaching TIMEOUT_CYCLES without rx_valid SHALL select NAK and move to RESP.
REQ-033 Without FRAME_TIMEOUT_EN, no timeout counter SHALL exist and partial frames SHALL wait indefinitely.

Structure
REQ-034 A shared package SHALL hold the state enum, ACK/NAK byte constants, and default SOF.
REQ-035 The payload buffer SHALL be one sub-module, frame_buffer (single write port, single read port, registered read index).

Verification
REQ-036 A5 03 11 22 33 03, m_ready=1 -> m_data 11,22,33, m_last on 33, then tx_data=06 pulse.
REQ-037 A5 03 11 22 33 00 -> no m_valid, frame_err pulse, tx_data=15.
REQ-038 A5 00 then A5 41 (MAX_LEN=64) -> NAK each, FSM back in IDLE.
REQ-039 Valid frame, m_ready toggled 1-0-0-1 with tx_ready=0 for 10 cycles -> data held stable, no byte lost/duplicated, ACK sent once tx_ready=1.
REQ-040 FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: A5 02 11 then idle -> NAK within 101 cycles; reset_n low mid-payload -> IDLE, no tx_send.
